// File: rtl/table_pkg.sv
// -----------------------------------------------------------------------------
// table_pkg
// Shared table geometry and scanner state type. The hole drawing objects and
// the pocket scanner both import this package, so the drawn pockets and the
// detected pockets always come from the same coordinate table.
//
// Contents:
//   NUM_HOLES, HOLE_SIZE      hole count and sprite size in pixels
//   HOLE_X / HOLE_Y           hole sprite top-left coordinates
//   scan_state_t              pocket scanner FSM states
//   hole_centre_x/_y          hole centre lookup by hole index
// -----------------------------------------------------------------------------
package table_pkg;

    localparam int NUM_HOLES = 6;
    localparam int HOLE_SIZE = 32;

    localparam logic signed [11:0] HOLE_X [NUM_HOLES] = '{
        12'sd16, 12'sd304, 12'sd592, 12'sd16, 12'sd304, 12'sd592
    };
    localparam logic signed [11:0] HOLE_Y [NUM_HOLES] = '{
        12'sd16, 12'sd16, 12'sd16, 12'sd432, 12'sd432, 12'sd432
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUB,
        SQX,
        SQY,
        CMP,
        EMIT,
        DONE
    } scan_state_t;

    // Out-of-range indices return 0; the scanner never presents one.
    function automatic logic signed [11:0] hole_centre_x(input logic [2:0] idx);
        logic signed [11:0] r;
        r = 12'sd0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (idx == 3'(i)) begin
                r = HOLE_X[i] + 12'(HOLE_SIZE / 2);
            end
        end
        return r;
    endfunction

    function automatic logic signed [11:0] hole_centre_y(input logic [2:0] idx);
        logic signed [11:0] r;
        r = 12'sd0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (idx == 3'(i)) begin
                r = HOLE_Y[i] + 12'(HOLE_SIZE / 2);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dist_sq_unit.sv
// -----------------------------------------------------------------------------
// dist_sq_unit
// Squared-distance datapath for the pocket scanner. One 12x12 multiplier is
// shared between the X and Y terms; the FSM sequences it.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           register dx/dy from the centre/hole inputs, zero acc
//   sel_x           acc = dx*dx
//   sel_y           acc = acc + dy*dy
//   cx, cy          ball centre (12-bit signed)
//   hx, hy          hole centre (12-bit signed)
//   acc             25-bit squared distance
// -----------------------------------------------------------------------------
module dist_sq_unit (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               sel_x,
    input  logic               sel_y,
    input  logic signed [11:0] cx,
    input  logic signed [11:0] cy,
    input  logic signed [11:0] hx,
    input  logic signed [11:0] hy,
    output logic        [24:0] acc
);

    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic signed [11:0] mul_op;
    logic signed [23:0] product;

    // Squares are always non-negative and below 2^23 for 12-bit operands, so
    // the low 24 bits of the sign-extended product are the exact result.
    always_comb begin
        mul_op  = sel_y ? dy : dx;
        product = 24'(mul_op) * 24'(mul_op);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx  <= '0;
            dy  <= '0;
            acc <= '0;
        end else if (clear) begin
            dx  <= cx - hx;
            dy  <= cy - hy;
            acc <= '0;
        end else if (sel_x) begin
            acc <= {1'b0, product};
        end else if (sel_y) begin
            acc <= acc + {1'b0, product};
        end
    end

endmodule

// File: rtl/pocket_scanner.sv
// -----------------------------------------------------------------------------
// pocket_scanner
// Once per frame, walks every active ball against the six table holes and
// reports each pocketed ball (first matching hole only) as a valid/ready event.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start_of_frame    single-cycle pulse that starts a scan
//   ball_x, ball_y    per-ball top-left position, 11-bit signed each
//   ball_active       1 = ball is on the table
//   pocket_valid      pocket event pending (held until pocket_ready)
//   pocket_ready      consumer accepts the event
//   pocket_ball_id    id of the pocketed ball
//   pocket_hole_id    id of the hole, 0..5
//   busy              scan in progress
//   scan_done         single-cycle pulse when a scan completes
//   overrun           single-cycle pulse when start_of_frame arrives while busy
// -----------------------------------------------------------------------------
module pocket_scanner
    import table_pkg::*;
#(
    parameter int NUM_BALLS   = 16,
    parameter int BALL_RADIUS = 8,
    parameter int POCKET_R_SQ = 196
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_of_frame,
    input  logic [NUM_BALLS-1:0][10:0]  ball_x,
    input  logic [NUM_BALLS-1:0][10:0]  ball_y,
    input  logic [NUM_BALLS-1:0]        ball_active,
    output logic                        pocket_valid,
    input  logic                        pocket_ready,
    output logic [3:0]                  pocket_ball_id,
    output logic [2:0]                  pocket_hole_id,
    output logic                        busy,
    output logic                        scan_done,
    output logic                        overrun
);

    localparam logic [3:0] LAST_BALL = 4'(NUM_BALLS - 1);
    localparam logic [2:0] LAST_HOLE = 3'(NUM_HOLES - 1);

    scan_state_t        state, state_n;
    logic [3:0]         ball_idx, ball_n;
    logic [2:0]         hole_idx, hole_n;
    logic signed [11:0] cx, cy;
    logic               latch;
    logic               clear, sel_x, sel_y;
    logic [24:0]        acc;
    logic               in_pocket;
    logic               last_ball;

    dist_sq_unit u_dist (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .sel_x (sel_x),
        .sel_y (sel_y),
        .cx    (cx),
        .cy    (cy),
        .hx    (hole_centre_x(hole_idx)),
        .hy    (hole_centre_y(hole_idx)),
        .acc   (acc)
    );

    assign in_pocket = (acc < 25'(POCKET_R_SQ));
    assign last_ball = (ball_idx == LAST_BALL);

    // Next-state and datapath control. A handshake in EMIT skips the remaining
    // holes of that ball, so each ball yields at most one event per scan.
    always_comb begin
        state_n = state;
        ball_n  = ball_idx;
        hole_n  = hole_idx;
        latch   = 1'b0;
        clear   = 1'b0;
        sel_x   = 1'b0;
        sel_y   = 1'b0;
        case (state)
            IDLE: begin
                if (start_of_frame) begin
                    ball_n  = '0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (!ball_active[ball_idx]) begin
                    if (last_ball) begin
                        state_n = DONE;
                    end else begin
                        ball_n = ball_idx + 4'd1;
                    end
                end else begin
                    latch   = 1'b1;
                    hole_n  = '0;
                    state_n = SUB;
                end
            end
            SUB: begin
                clear   = 1'b1;
                state_n = SQX;
            end
            SQX: begin
                sel_x   = 1'b1;
                state_n = SQY;
            end
            SQY: begin
                sel_y   = 1'b1;
                state_n = CMP;
            end
            CMP: begin
                if (in_pocket) begin
                    state_n = EMIT;
                end else if (hole_idx < LAST_HOLE) begin
                    hole_n  = hole_idx + 3'd1;
                    state_n = SUB;
                end else if (last_ball) begin
                    state_n = DONE;
                end else begin
                    ball_n  = ball_idx + 4'd1;
                    state_n = LOAD;
                end
            end
            EMIT: begin
                if (pocket_ready) begin
                    if (last_ball) begin
                        state_n = DONE;
                    end else begin
                        ball_n  = ball_idx + 4'd1;
                        state_n = LOAD;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Ball positions are sampled only here, so a ball moving mid-scan is
    // judged at the position it had when its LOAD cycle ran.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ball_idx <= '0;
            hole_idx <= '0;
            cx       <= '0;
            cy       <= '0;
        end else begin
            state    <= state_n;
            ball_idx <= ball_n;
            hole_idx <= hole_n;
            if (latch) begin
                cx <= {ball_x[ball_idx][10], ball_x[ball_idx]} + 12'(BALL_RADIUS);
                cy <= {ball_y[ball_idx][10], ball_y[ball_idx]} + 12'(BALL_RADIUS);
            end
        end
    end

    // Event ids come straight from the counters, which cannot move while EMIT
    // waits for pocket_ready.
    assign pocket_valid   = (state == EMIT);
    assign pocket_ball_id = ball_idx;
    assign pocket_hole_id = hole_idx;
    assign busy           = (state != IDLE);
    assign scan_done      = (state == DONE);
    assign overrun        = start_of_frame && (state != IDLE);

endmodule

// File: tb/tb_pocket_scanner.sv
// -----------------------------------------------------------------------------
// tb_pocket_scanner
// Self-checking bench for pocket_scanner. A reference model computes, from the
// ball table and the per-ball cycle costs, the exact cycle of every pocket
// event, handshake and scan_done; the DUT is compared against it every cycle.
// -----------------------------------------------------------------------------
module tb_pocket_scanner;

    localparam int NB   = 16;
    localparam int MAXC = 2048;
    localparam int HX [6] = '{16, 304, 592, 16, 304, 592};
    localparam int HY [6] = '{16, 16, 16, 432, 432, 432};

    logic                 clk;
    logic                 rst;
    logic                 start_of_frame;
    logic [NB-1:0][10:0]  ball_x;
    logic [NB-1:0][10:0]  ball_y;
    logic [NB-1:0]        ball_active;
    logic                 pocket_valid;
    logic                 pocket_ready;
    logic [3:0]           pocket_ball_id;
    logic [2:0]           pocket_hole_id;
    logic                 busy;
    logic                 scan_done;
    logic                 overrun;

    int checks   = 0;
    int failures = 0;

    int bx [NB];
    int by [NB];
    int wait_for [NB];
    bit act [NB];

    bit exp_valid [MAXC];
    int exp_ball  [MAXC];
    int exp_hole  [MAXC];
    bit ready_at  [MAXC];
    int t_done;
    int first_emit;
    int obs_done;

    pocket_scanner #(
        .NUM_BALLS   (16),
        .BALL_RADIUS (8),
        .POCKET_R_SQ (196)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_of_frame (start_of_frame),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .ball_active    (ball_active),
        .pocket_valid   (pocket_valid),
        .pocket_ready   (pocket_ready),
        .pocket_ball_id (pocket_ball_id),
        .pocket_hole_id (pocket_hole_id),
        .busy           (busy),
        .scan_done      (scan_done),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // First hole (in table order) whose centre is strictly closer than 14 px.
    function automatic int first_hole(input int x, input int y);
        int dx, dy;
        for (int h = 0; h < 6; h++) begin
            dx = (x + 8) - (HX[h] + 16);
            dy = (y + 8) - (HY[h] + 16);
            if (dx * dx + dy * dy < 196) return h;
        end
        return -1;
    endfunction

    // Cycle 0 carries the start pulse; cycle 1 is the first LOAD. Costs:
    // inactive 1, missed 25, pocketed 1 + 4*(h+1) + wait + 1.
    task automatic build_model();
        int t, h;
        for (int c = 0; c < MAXC; c++) begin
            exp_valid[c] = 1'b0;
            exp_ball[c]  = 0;
            exp_hole[c]  = 0;
            ready_at[c]  = 1'($urandom_range(0, 1));
        end
        t = 1;
        first_emit = -1;
        for (int i = 0; i < NB; i++) begin
            if (!act[i]) begin
                t += 1;
            end else begin
                t += 1;
                h = first_hole(bx[i], by[i]);
                if (h < 0) begin
                    t += 24;
                end else begin
                    t += 4 * (h + 1);
                    if (first_emit < 0) first_emit = t;
                    for (int w = 0; w <= wait_for[i]; w++) begin
                        exp_valid[t + w] = 1'b1;
                        exp_ball[t + w]  = i;
                        exp_hole[t + w]  = h;
                        ready_at[t + w]  = (w == wait_for[i]);
                    end
                    t += wait_for[i] + 1;
                end
            end
        end
        t_done = t;
    endtask

    task automatic clear_balls();
        for (int i = 0; i < NB; i++) begin
            act[i] = 1'b0;
            bx[i] = 0;
            by[i] = 0;
            wait_for[i] = 0;
        end
    endtask

    task automatic pack_balls();
        for (int i = 0; i < NB; i++) begin
            ball_x[i]      = 11'(bx[i]);
            ball_y[i]      = 11'(by[i]);
            ball_active[i] = act[i];
        end
    endtask

    // Runs one scan, checking every cycle. overrun_at < 0 means no second
    // start pulse; abort_in_emit resets the DUT two cycles into the first EMIT.
    task automatic applyStimulus(input int overrun_at, input bit abort_in_emit);
        int last, abort_at;
        pack_balls();
        build_model();
        abort_at = (abort_in_emit && first_emit > 0) ? first_emit + 2 : -1;
        last = (abort_at > 0) ? abort_at : t_done + 1;
        obs_done = -1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            start_of_frame = (c == 0) || (c == overrun_at);
            pocket_ready   = ready_at[c];
            #1;
            checkOutput("pocket_valid", 32'(pocket_valid), 32'(exp_valid[c]));
            if (exp_valid[c]) begin
                checkOutput("pocket_ball_id", 32'(pocket_ball_id), 32'(exp_ball[c]));
                checkOutput("pocket_hole_id", 32'(pocket_hole_id), 32'(exp_hole[c]));
            end
            checkOutput("busy", 32'(busy), 32'(c >= 1 && c <= t_done));
            checkOutput("scan_done", 32'(scan_done), 32'(c == t_done));
            checkOutput("overrun", 32'(overrun), 32'(c == overrun_at));
            if (scan_done && obs_done < 0) obs_done = c;
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                checkOutput("rst_valid_drop", 32'(pocket_valid), 32'd0);
                checkOutput("rst_busy_drop", 32'(busy), 32'd0);
            end
        end
        start_of_frame = 1'b0;
        if (abort_at > 0) begin
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                #1;
                checkOutput("post_rst_scan_done", 32'(scan_done), 32'd0);
                checkOutput("post_rst_busy", 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        start_of_frame = 1'b0;
        pocket_ready   = 1'b0;
        clear_balls();
        pack_balls();

        @(negedge clk);
        #1;
        checkOutput("reset_valid", 32'(pocket_valid), 32'd0);
        checkOutput("reset_ball_id", 32'(pocket_ball_id), 32'd0);
        checkOutput("reset_hole_id", 32'(pocket_hole_id), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_scan_done", 32'(scan_done), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] all balls inactive");
        clear_balls();
        applyStimulus(-1, 1'b0);
        checkOutput("inactive_done_cycle", 32'(obs_done), 32'd17);

        $display("[TB] ball 0 far from every hole");
        clear_balls();
        act[0] = 1'b1; bx[0] = 500; by[0] = 200;
        applyStimulus(-1, 1'b0);
        checkOutput("far_ball_done_cycle", 32'(obs_done), 32'd41);

        $display("[TB] ball 3 centred on hole 0");
        clear_balls();
        act[3] = 1'b1; bx[3] = 24; by[3] = 24;
        applyStimulus(-1, 1'b0);
        checkOutput("hole0_done_cycle", 32'(obs_done), 32'd22);

        $display("[TB] ball 5 at radius boundary of hole 4");
        clear_balls();
        act[5] = 1'b1; bx[5] = 326; by[5] = 440;
        applyStimulus(-1, 1'b0);
        checkOutput("edge196_done_cycle", 32'(obs_done), 32'd41);
        bx[5] = 325;
        applyStimulus(-1, 1'b0);

        $display("[TB] two pockets with back-pressure and overrun");
        clear_balls();
        act[2] = 1'b1; bx[2] = 312; by[2] = 24;  wait_for[2] = 10;
        act[7] = 1'b1; bx[7] = 600; by[7] = 440; wait_for[7] = 10;
        applyStimulus(5, 1'b0);

        $display("[TB] reset during EMIT then fresh scan");
        clear_balls();
        act[3] = 1'b1; bx[3] = 24; by[3] = 24; wait_for[3] = 5;
        applyStimulus(-1, 1'b1);
        wait_for[3] = 0;
        applyStimulus(-1, 1'b0);
        checkOutput("fresh_scan_done_cycle", 32'(obs_done), 32'd22);

        $display("[TB] randomized scans");
        for (int s = 0; s < 8; s++) begin
            int h, mode;
            clear_balls();
            for (int i = 0; i < NB; i++) begin
                act[i] = 1'($urandom_range(0, 1));
                mode = int'($urandom_range(0, 3));
                if (mode == 0) begin
                    h = int'($urandom_range(0, 5));
                    bx[i] = HX[h] + 8 + int'($urandom_range(0, 28)) - 14;
                    by[i] = HY[h] + 8 + int'($urandom_range(0, 28)) - 14;
                end else if (mode == 1) begin
                    bx[i] = int'($urandom_range(0, 2047)) - 1024;
                    by[i] = int'($urandom_range(0, 2047)) - 1024;
                end else begin
                    bx[i] = int'($urandom_range(0, 620));
                    by[i] = int'($urandom_range(0, 460));
                end
                wait_for[i] = int'($urandom_range(0, 3));
            end
            applyStimulus((s % 2 == 1) ? int'($urandom_range(1, 16)) : -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
